// File: rtl/led_arbiter_pkg.sv
// Shared types and constants for the LED arbiter and its helpers.
package led_arbiter_pkg;

    // Width of the board's user LED bank.
    localparam int LED_W = 4;

    // Arbiter FSM: nobody owns the LEDs, or one channel holds them.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/strobe_div.sv
// Periodic strobe generator: a single-cycle pulse every DIV_BY clock cycles.
// The first pulse appears DIV_BY cycles after reset is released.
module strobe_div #(
    parameter int unsigned DIV_BY = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   CW   = (DIV_BY > 1) ? $clog2(DIV_BY) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV_BY - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Free-running modulo-DIV_BY counter; the strobe is registered off the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing the 4 user LEDs between CH pattern sources.
// Decisions happen only on divider ticks; each grant is held for at least
// HOLD_TICKS ticks unless its requester lets go first.
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int unsigned CH         = 4,
    parameter int unsigned DIV_BY     = 100_000_000,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH-1:0]           req,
    input  logic [LED_W*CH-1:0]     pat,
    output logic [LED_W-1:0]        led,
    output logic [CH-1:0]           grant,
    output logic [$clog2(CH)-1:0]   grant_id,
    output logic                    tick
);

    localparam int unsigned IDW = $clog2(CH);
    localparam int unsigned EW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    // Round-robin search starting just after `last`; the previous holder is
    // visited last so it is only re-granted when nobody else is asking.
    // Result is {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [CH-1:0]  r,
                                             input logic [IDW-1:0] last);
        logic           found;
        logic [IDW-1:0] id;
        int unsigned    idx;
        found = 1'b0;
        id    = '0;
        for (int unsigned k = 1; k <= CH; k++) begin
            idx = (32'(last) + k) % CH;
            if (!found && r[IDW'(idx)]) begin
                found = 1'b1;
                id    = IDW'(idx);
            end
        end
        return {found, id};
    endfunction

    logic                 w_tick;
    logic                 w_pick_found;
    logic [IDW-1:0]       w_pick_id;
    logic [LED_W-1:0]     w_sel_pat;
    logic                 w_expire;

    arb_state_t           r_state;
    logic [CH-1:0]        r_grant;
    logic [IDW-1:0]       r_grant_id;
    logic [IDW-1:0]       r_last;
    logic [EW-1:0]        r_elapsed;
    logic [LED_W-1:0]     r_led;

    strobe_div #(
        .DIV_BY(DIV_BY)
    ) u_strobe_div (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    // Next candidate for the LEDs given the live requests and the RR pointer.
    always_comb begin
        {w_pick_found, w_pick_id} = rr_pick(req, r_last);
    end

    // Pattern of the current holder, selected by the registered grant index.
    always_comb begin
        w_sel_pat = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (IDW'(i) == r_grant_id) begin
                w_sel_pat = pat[i*LED_W +: LED_W];
            end
        end
    end

    // The current grant has used up its minimum hold at this tick.
    always_comb begin
        w_expire = ((32'(r_elapsed) + 32'd1) == HOLD_TICKS);
    end

    // Arbitration FSM with registered grant, grant index and LED output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= IDW'(CH - 1);
            r_elapsed  <= '0;
            r_led      <= '0;
        end else begin
            // LEDs follow the holder registered in the previous cycle, so
            // they trail any grant change by exactly one clock.
            r_led <= (r_state == HOLD) ? w_sel_pat : '0;

            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_pick_found) begin
                            r_state    <= HOLD;
                            r_grant    <= CH'(1) << w_pick_id;
                            r_grant_id <= w_pick_id;
                            r_last     <= w_pick_id;
                            r_elapsed  <= '0;
                        end
                    end
                    HOLD: begin
                        if (!req[r_grant_id] || w_expire) begin
                            // A lone holder that still requests is found by
                            // the wrap-around search and simply re-granted.
                            if (w_pick_found) begin
                                r_grant    <= CH'(1) << w_pick_id;
                                r_grant_id <= w_pick_id;
                                r_last     <= w_pick_id;
                                r_elapsed  <= '0;
                            end else begin
                                r_state    <= IDLE;
                                r_grant    <= '0;
                                r_grant_id <= '0;
                            end
                        end else begin
                            r_elapsed <= r_elapsed + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign led      = r_led;
    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign tick     = w_tick;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (CH=4, DIV_BY=4, HOLD_TICKS=2).
// A cycle-level reference model pushes the expected outputs for each clock
// into a queue; they are popped and compared once the DUT has clocked.
module tb_led_arbiter;

    localparam int CH   = 4;
    localparam int DIV  = 4;
    localparam int HOLD = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  led;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        tick;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] led;
        logic [3:0] grant;
        logic [1:0] gid;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    // Reference model state (values visible after the most recent edge).
    int         m_cyc;
    bit         m_tick;
    bit         m_hold;
    int         m_gid;
    int         m_last;
    int         m_elapsed;
    logic [3:0] m_led;

    led_arbiter #(
        .CH        (CH),
        .DIV_BY    (DIV),
        .HOLD_TICKS(HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pat     (pat),
        .led     (led),
        .grant   (grant),
        .grant_id(grant_id),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_find(input logic [3:0] r, input int last);
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (last + k) % CH;
            if (r[2'(c)]) return c;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic [3:0] nled;
        int         pick;
        if (rst) begin
            m_cyc     = 0;
            m_tick    = 0;
            m_hold    = 0;
            m_gid     = 0;
            m_last    = CH - 1;
            m_elapsed = 0;
            m_led     = 4'h0;
        end else begin
            nled = m_hold ? 4'((pat >> (4 * m_gid)) & 16'hF) : 4'h0;
            if (m_tick) begin
                pick = rr_find(req, m_last);
                if (!m_hold || !req[2'(m_gid)] || (m_elapsed + 1 == HOLD)) begin
                    if (pick >= 0) begin
                        m_hold    = 1;
                        m_gid     = pick;
                        m_last    = pick;
                        m_elapsed = 0;
                    end else begin
                        m_hold = 0;
                        m_gid  = 0;
                    end
                end else begin
                    m_elapsed++;
                end
            end
            m_cyc++;
            m_tick = (m_cyc % DIV == 0);
            m_led  = nled;
        end
    endtask

    // One clock: predict, push, clock the DUT, pop and compare.
    task automatic step();
        exp_t e;
        exp_t o;
        model_edge();
        e.led   = m_led;
        e.grant = m_hold ? 4'(1 << m_gid) : 4'b0000;
        e.gid   = m_hold ? 2'(m_gid) : 2'd0;
        e.tick  = m_tick;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check("sb_led",      32'(led),      32'(o.led));
        check("sb_grant",    32'(grant),    32'(o.grant));
        check("sb_grant_id", 32'(grant_id), 32'(o.gid));
        check("sb_tick",     32'(tick),     32'(o.tick));
        check("onehot0",     32'($onehot0(grant)), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Step until the model reaches cycle n after reset release (bounded).
    task automatic run_to(input int n);
        for (int g = 0; g < 500 && m_cyc < n; g++) step();
        check("run_to", 32'(m_cyc), 32'(n));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        pat      = 16'h0000;

        // Everyone requests through reset: full rotation, 8 cycles per grant.
        req = 4'b1111;
        pat = 16'h8421;
        do_reset();
        check("s1_rst_grant", 32'(grant), 32'h0);
        check("s1_rst_led",   32'(led),   32'h0);
        run_to(3);
        check("s1_no_tick3", 32'(tick), 32'd0);
        run_to(4);
        check("s1_tick4",  32'(tick),  32'd1);
        check("s1_grant4", 32'(grant), 32'h0);
        run_to(5);
        check("s1_grant_ch0", 32'(grant), 32'b0001);
        run_to(12);
        check("s1_ch0_end", 32'(grant), 32'b0001);
        run_to(13);
        check("s1_grant_ch1", 32'(grant), 32'b0010);
        run_to(14);
        check("s1_led_ch1", 32'(led), 32'h2);
        run_to(21);
        check("s1_grant_ch2", 32'(grant), 32'b0100);
        run_to(29);
        check("s1_grant_ch3", 32'(grant), 32'b1000);
        run_to(37);
        check("s1_wrap_ch0", 32'(grant), 32'b0001);

        // Single requester re-granted across expiries.
        req = 4'b0100;
        pat = 16'h0A00;
        do_reset();
        run_to(5);
        check("s2_grant",    32'(grant),    32'b0100);
        check("s2_grant_id", 32'(grant_id), 32'd2);
        run_to(6);
        check("s2_led", 32'(led), 32'hA);
        run_to(40);
        check("s2_still", 32'(grant), 32'b0100);

        // Early release mid-hold.
        req = 4'b0010;
        pat = 16'h00F0;
        do_reset();
        run_to(6);
        req = 4'b0000;
        run_to(8);
        check("s3_held_till_tick", 32'(grant), 32'b0010);
        run_to(9);
        check("s3_idle_grant", 32'(grant), 32'h0);
        check("s3_led_lag",    32'(led),   32'hF);
        run_to(10);
        check("s3_idle_led", 32'(led), 32'h0);

        // Pattern change between ticks.
        req = 4'b0001;
        pat = 16'h0003;
        do_reset();
        run_to(6);
        check("s4_led_a", 32'(led), 32'h3);
        pat = 16'h000C;
        run_to(7);
        check("s4_led_b",  32'(led),   32'hC);
        check("s4_grant", 32'(grant), 32'b0001);

        // Request coincident with the tick is granted at that edge.
        req = 4'b0000;
        pat = 16'hC000;
        do_reset();
        run_to(4);
        req = 4'b1000;
        run_to(5);
        check("s5_same_tick", 32'(grant), 32'b1000);

        // Request one cycle late waits for the next tick.
        req = 4'b0000;
        do_reset();
        run_to(5);
        req = 4'b1000;
        run_to(8);
        check("s5_waiting", 32'(grant), 32'h0);
        run_to(9);
        check("s5_late", 32'(grant), 32'b1000);

        // Reset mid-hold with the divider at 2.
        req = 4'b1111;
        pat = 16'h8421;
        do_reset();
        run_to(14);
        check("s6_pre_rst", 32'(grant), 32'b0010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_led",   32'(led),   32'h0);
        check("s6_grant", 32'(grant), 32'h0);
        check("s6_tick",  32'(tick),  32'd0);
        run_to(4);
        check("s6_tick_again", 32'(tick), 32'd1);
        run_to(5);
        check("s6_ch0_first", 32'(grant), 32'b0001);

        // Random traffic with occasional resets; scoreboard only.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            pat = 16'($urandom);
            rst = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
